// File: rtl/uart_tx_fsm.sv
// 8N1 UART transmitter, LSB first, stepped by rising edges of an external baud tick.
// A request is latched immediately and the frame starts on the next tick rising edge.
module uart_tx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx,
    output logic                  tx_busy
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StStart = 2'b01,
        StData  = 2'b10,
        StStop  = 2'b11
    } state_e;

    state_e                state, state_d;
    logic                  tick_q;
    logic                  tick_rise;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;

    // tick_q resets high so a tick already high at reset release is not an edge
    assign tick_rise = tick & ~tick_q;

    always_comb begin
        state_d   = state;
        pending_d = pending_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;

        unique case (state)
            StIdle: begin
                if (pending_q) begin
                    if (tick_rise) begin
                        state_d   = StStart;
                        pending_d = 1'b0;
                    end
                end else if (tx_start) begin
                    shift_d   = tx_data;
                    pending_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            StStart: begin
                if (tick_rise) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                if (tick_rise) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (tick_rise) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the state being entered, so tx changes on the same edge as state
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StIdle:  tx_d = 1'b1;
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            StStop:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StIdle;
            tick_q    <= 1'b1;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_d;
            tick_q    <= tick;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: a frame-level line model checked every cycle, plus directed
// frames whose bit sequences are written out by hand.
module tb_uart_tx_fsm;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          tick;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx;
    logic          tx_busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;
    bit tick_hold = 0;

    uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Square-wave tick, one rising edge per 100 clks; tick_hold freezes its level
    initial begin
        tick = 0;
        forever begin
            repeat (50) @(posedge clk);
            #1;
            if (!tick_hold) tick = ~tick;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Frame model: a frame is a list of DW+2 line levels, advanced once per tick edge
    bit            m_busy   = 0;
    bit            m_active = 0;
    bit            m_tickq  = 1;
    bit            m_rise;
    int            m_idx    = 0;
    logic [DW+1:0] m_frame  = '1;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy   = 0;
            m_active = 0;
            m_tickq  = 1;
            m_idx    = 0;
        end else begin
            m_rise  = tick && !m_tickq;
            m_tickq = tick;
            if (m_active) begin
                if (m_rise) begin
                    m_idx++;
                    if (m_idx == DW + 2) begin
                        m_active = 0;
                        m_busy   = 0;
                    end
                end
            end else if (m_busy) begin
                if (m_rise) begin
                    m_active = 1;
                    m_idx    = 0;
                end
            end else if (tx_start) begin
                m_busy  = 1;
                m_frame = {1'b1, tx_data, 1'b0};
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tx", tx, m_active ? m_frame[m_idx] : 1'b1);
            check("model_busy", tx_busy, m_busy);
        end
    end

    task automatic align();
        @(posedge tick);
        repeat (5) @(negedge clk);
    endtask

    // Called at a negedge; request is accepted on the following posedge
    task automatic send(input logic [DW-1:0] d);
        tx_start = 1;
        tx_data  = d;
        @(negedge clk);
        tx_start = 0;
        tx_data  = ~d;
        check("busy_after_accept", tx_busy, 1);
        check("idle_line_after_accept", tx, 1);
    endtask

    // exp[k] is the line level after the k-th tick edge (bit 0 = start bit)
    task automatic frame_check(input logic [DW+1:0] exp, input int inject);
        int n;
        for (int k = 0; k < DW + 2; k++) begin
            @(posedge tick);
            repeat (3) @(negedge clk);
            check($sformatf("frame_bit%0d", k), tx, exp[k]);
            if (k == inject) begin
                @(negedge clk);
                tx_start = 1;
                tx_data  = 8'hFF;
                @(negedge clk);
                tx_start = 0;
            end
        end
        @(posedge tick);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_busy === 1'b1 && n < 6);
        check("busy_fall", tx_busy, 0);
        check("busy_fall_clk", n, 2);
        check("line_after_frame", tx, 1);
    endtask

    initial begin
        rst      = 0;
        tx_start = 0;
        tx_data  = '0;
        @(posedge clk);
        chk_en = 1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_busy", tx_busy, 0);
            check("rst_state", 32'(dut.state), 0);
        end
        rst = 1;

        align();
        send(8'h55);
        frame_check(10'b1_01010101_0, -1);

        // Tick frozen high: request stays pending with no line activity
        align();
        tick_hold = 1;
        send(8'hAA);
        repeat (300) @(negedge clk);
        check("hold_tx", tx, 1);
        check("hold_busy", tx_busy, 1);
        check("hold_state", 32'(dut.state), 0);
        tick_hold = 0;
        frame_check(10'b1_10101010_0, -1);

        align();
        send(8'h12);
        frame_check(10'b1_00010010_0, -1);
        send(8'h34);
        frame_check(10'b1_00110100_0, -1);
        send(8'h56);
        frame_check(10'b1_01010110_0, -1);

        align();
        send(8'h00);
        frame_check(10'b1_00000000_0, 3);
        repeat (150) @(negedge clk);
        check("no_extra_busy", tx_busy, 0);
        check("no_extra_tx", tx, 1);

        // Reset during data bit 3
        align();
        send(8'h55);
        repeat (5) @(posedge tick);
        repeat (10) @(negedge clk);
        check("pre_abort_state", 32'(dut.state), 2);
        check("pre_abort_tx", tx, 1'b0);
        rst = 0;
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_state", 32'(dut.state), 0);
        @(negedge clk);
        rst = 1;
        align();
        send(8'h55);
        frame_check(10'b1_01010101_0, -1);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
UART transmitter core, 8N1 framing, LSB first. Bit timing comes from an external baud tick; the block produces the serial line `tx` and a `tx_busy` flag. It sits between the baud-rate generator and the pad, and is driven by a host that pulses `tx_start` with a byte on `tx_data`.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; tx_data width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- tick  input  1  baud timing input; may be a 1-clk strobe or a slow square wave.
- tx_start  input  1  request to send; sampled every clk.
- tx_data  input  DATA_WIDTH  byte to send; sampled only in the cycle the request is accepted.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high from acceptance until the frame completes.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, tx=1, tx_busy=0, pending=0, bit counter=0, shift register=0.
  - tick_q=1, so a tick that is already high at reset release does not count as an edge.
- Baud event: `tick_rise = tick & ~tick_q`, with tick_q registered every clk. All bit-time transitions happen only on tick_rise. One bit period equals the interval between consecutive tick rising edges.
- State register is 2 bits and named `state`: IDLE=00, START=01, DATA=10, STOP=11.
- tx is registered and is a function of state:
  - IDLE → 1
  - START → 0
  - DATA → shift_reg[0]
  - STOP → 1
- IDLE:
  - If tx_start=1 and pending=0: latch tx_data into shift_reg, set pending=1, and set tx_busy=1 on the next clk edge (1-cycle latency).
  - On tick_rise with pending=1: go to START, clear pending.
- START: on tick_rise, go to DATA with bit counter=0.
- DATA:
  - On tick_rise: shift shift_reg right by 1, increment counter.
  - After DATA_WIDTH tick_rise events (counter reaches DATA_WIDTH-1 and a tick_rise occurs): go to STOP.
- STOP: on tick_rise, go to IDLE and clear tx_busy in the same clk edge.
- Frame length: exactly 1+DATA_WIDTH+1 full bit periods after the first tick_rise following acceptance. Waiting for that first tick_rise takes 0 to 1 bit period.
- tx_start while tx_busy=1 is ignored; no queuing, and the in-flight data is never altered. tx_data changes after acceptance have no effect.
- Back-to-back: tx_start asserted in the first cycle tx_busy=0 is accepted normally. tx stays 1 for at least the wait until the next tick_rise, so the line has ≥1 idle gap between frames.
- tick held high or low indefinitely: no transitions and no spurious edges. A tick strobe longer than 1 clk counts once.
- Reset mid-frame aborts immediately: tx=1, tx_busy=0, state=IDLE, and the partial frame is lost.
- tx_start held high for multiple cycles: accepted once. After that frame completes, it is accepted again if still high.

Test Plan:
- Reset with rst=0 for 10 clks, tick toggling (period 100 clks) → tx=1, tx_busy=0, state=00 throughout.
- Send 0x55 (1-clk tx_start pulse) → tx_busy=1 next clk. At successive tick rising edges tx goes 0 (start), then 1,0,1,0,1,0,1,0 (LSB first), then 1 (stop). tx_busy falls on the 10th edge after start; each bit lasts exactly 100 clks.
- Send 0xAA → tx sequence 0, 0,1,0,1,0,1,0,1, 1. States step 00→01→10(×8 bits)→11→00.
- Continuous 0x12, 0x34, 0x56, each started the cycle tx_busy falls → three complete frames with data bits 0,1,0,0,1,0,0,0 / 0,0,1,0,1,1,0,0 / 0,1,1,0,1,0,1,0, and tx=1 between frames.
- Pulse tx_start with 0xFF during a 0x00 frame → ignored. Line shows exactly 0x00 (start bit, eight 0s, stop), with no extra frame.
- Assert rst=0 during DATA bit 3 → next clk tx=1, tx_busy=0, state=00. A new 0x55 request after release transmits correctly.
